// File: rtl/buffer_memory_if.sv
// rtl/buffer_memory_if.sv - write/read port bundle for buffer_memory
// master drives addresses, data and enables; slave returns registered read data.
interface buffer_memory_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output addr_wr, addr_rd, data_in, wr_en, rd_en,
    input  data_out
  );

  modport slave (
    input  addr_wr, addr_rd, data_in, wr_en, rd_en,
    output data_out
  );
endinterface

// File: rtl/buffer_memory.sv
// rtl/buffer_memory.sv - simple dual-port RAM with registered read port
// BUFFER_MEMORY_RDW_BYPASS_EN selects write-first forwarding on read/write collision (default read-first).
module buffer_memory #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  buffer_memory_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  collision;

  // Storage is never cleared; a low reset only blocks the write.
  always_ff @(posedge clk) begin
    if (reset && bus.wr_en) begin
      mem_q[bus.addr_wr] <= bus.data_in;
    end
  end

  assign collision = bus.wr_en && (bus.addr_wr == bus.addr_rd);

  always_comb begin
    data_out_d = data_out_q;
    if (bus.rd_en) begin
`ifdef BUFFER_MEMORY_RDW_BYPASS_EN
      data_out_d = collision ? bus.data_in : mem_q[bus.addr_rd];
`else
      // mem_q still holds the pre-write word here, giving read-first.
      data_out_d = mem_q[bus.addr_rd];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

`ifndef BUFFER_MEMORY_RDW_BYPASS_EN
  logic unused_collision;
  assign unused_collision = collision;
`endif
endmodule

// File: tb/tb_buffer_memory.sv
// tb/tb_buffer_memory.sv - directed self-checking bench for buffer_memory
module tb_buffer_memory;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [DW-1:0] exp_coll;

  buffer_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  buffer_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] exp);
    n_cmp++;
    assert (bus.data_out === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, bus.data_out, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ar);
    bus.wr_en   = we;
    bus.addr_wr = aw;
    bus.data_in = d;
    bus.rd_en   = re;
    bus.addr_rd = ar;
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, '0);
    step();
    step();
    check("reset_state", 32'h0);
    reset = 1'b1;

    drive(1'b1, 14'd0, 32'h0000ABCD, 1'b0, '0); step();
    drive(1'b1, 14'd1, 32'h0000EF01, 1'b0, '0); step();
    drive(1'b1, 14'd2, 32'h00002345, 1'b0, '0); step();

    drive(1'b0, '0, '0, 1'b1, 14'd0);
    #1 check("latency_before_edge", 32'h0);
    step(); check("read0", 32'h0000ABCD);
    drive(1'b0, '0, '0, 1'b1, 14'd1); step(); check("read1", 32'h0000EF01);
    drive(1'b0, '0, '0, 1'b1, 14'd2); step(); check("read2", 32'h00002345);

`ifdef BUFFER_MEMORY_RDW_BYPASS_EN
    exp_coll = 32'hAAAAAAAA;
`else
    exp_coll = 32'h0000ABCD;
`endif
    drive(1'b1, 14'd0, 32'hAAAAAAAA, 1'b1, 14'd0); step(); check("collision", exp_coll);
    drive(1'b1, 14'd1, 32'hBBBBBBBB, 1'b1, 14'd2); step(); check("disjoint_rd2", 32'h00002345);
    drive(1'b0, '0, '0, 1'b1, 14'd1); step(); check("disjoint_rd1", 32'hBBBBBBBB);
    drive(1'b0, '0, '0, 1'b1, 14'd0); step(); check("collision_after", 32'hAAAAAAAA);
    drive(1'b0, '0, '0, 1'b1, 14'd2); step(); check("pre_hold_rd2", 32'h00002345);

    drive(1'b1, 14'd2, 32'h12345678, 1'b0, 14'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_%0d", i), 32'h00002345);
    end
    drive(1'b0, '0, '0, 1'b1, 14'd2); step(); check("post_hold_rd2", 32'h12345678);

    drive(1'b1, 14'h3FFF, 32'hDEADBEEF, 1'b0, '0); step();
    drive(1'b1, 14'd0, 32'h0, 1'b0, '0); step();
    drive(1'b0, '0, '0, 1'b1, 14'h3FFF); step(); check("top_addr", 32'hDEADBEEF);
    drive(1'b0, '0, '0, 1'b1, 14'd0); step(); check("addr0_zero", 32'h0);
    drive(1'b0, '0, '0, 1'b1, 14'h3FFF); step(); check("pre_reset", 32'hDEADBEEF);

    #2 reset = 1'b0;
    #1 check("async_reset", 32'h0);
    drive(1'b1, 14'h3FFF, 32'h11111111, 1'b1, 14'h3FFF);
    step(); check("reset_ignores_read", 32'h0);
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0); step(); check("idle_after_reset", 32'h0);
    drive(1'b0, '0, '0, 1'b1, 14'h3FFF); step(); check("retained_top", 32'hDEADBEEF);
    drive(1'b0, '0, '0, 1'b1, 14'd1); step(); check("retained_1", 32'hBBBBBBBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
